// File: rtl/wb_stream_hub.sv
// wb_stream_hub: Wishbone slave that bridges a 32-bit CPU I/O bus to NCH
// byte-wide ready/valid stream channels. Each channel owns a TX FIFO
// (CPU -> stream) and an RX FIFO (stream -> CPU). Registers per channel
// (16-byte stride): DATA, STATUS, LEVEL, IE. One combined, registered irq.
module wb_stream_hub #(
    parameter int NCH        = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [31:0]           dat_i,
    output logic [31:0]           dat_o,
    input  logic                  we_i,
    input  logic [3:0]            sel_i,
    input  logic                  stb_i,
    input  logic                  cyc_i,
    output logic                  ack_o,
    output logic                  irq,
    output logic [NCH*8-1:0]      tx_data,
    output logic [NCH-1:0]        tx_valid,
    input  logic [NCH-1:0]        tx_ready,
    input  logic [NCH*8-1:0]      rx_data,
    input  logic [NCH-1:0]        rx_valid,
    output logic [NCH-1:0]        rx_ready
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PTR_W = DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam int CH_W  = ADDR_WIDTH - 4;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_LEVEL  = 2'd2;
    localparam logic [1:0] REG_IE     = 2'd3;

    // Bus decode shared by all channels
    logic            acc_s;
    logic [CH_W-1:0] ch_idx_s;
    logic [1:0]      reg_sel_s;
    logic            ch_valid_s;
    logic [31:0]     rd_word_s;

    // Registered bus outputs and interrupt
    logic            ack_r;
    logic [31:0]     dat_r;
    logic            irq_r;

    // Per-channel read words and interrupt conditions
    logic [NCH-1:0][31:0] data_word_s;
    logic [NCH-1:0][31:0] status_word_s;
    logic [NCH-1:0][31:0] level_word_s;
    logic [NCH-1:0][31:0] ie_word_s;
    logic [NCH-1:0]       irq_cond_s;

    // Address bits below the word and data bits above the flush controls
    // carry no meaning for this block.
    logic unused_bits_s;
    assign unused_bits_s = &{1'b0, adr_i[1:0], sel_i[3:2], dat_i[31:10]};

    // Transaction acceptance and address split
    always_comb begin
        acc_s      = cyc_i & stb_i & ~ack_r;
        ch_idx_s   = adr_i[ADDR_WIDTH-1:4];
        reg_sel_s  = adr_i[3:2];
        ch_valid_s = ({{(32-CH_W){1'b0}}, ch_idx_s} < 32'(NCH));
    end

    // Read-data mux; out-of-range channels and writes return zero
    always_comb begin
        rd_word_s = 32'h0000_0000;
        for (int i = 0; i < NCH; i++) begin
            if (!we_i && ch_valid_s && (ch_idx_s == CH_W'(i))) begin
                case (reg_sel_s)
                    REG_DATA:   rd_word_s = data_word_s[i];
                    REG_STATUS: rd_word_s = status_word_s[i];
                    REG_LEVEL:  rd_word_s = level_word_s[i];
                    REG_IE:     rd_word_s = ie_word_s[i];
                    default:    rd_word_s = 32'h0000_0000;
                endcase
            end else begin
                rd_word_s = rd_word_s;
            end
        end
    end

    // Single-cycle acknowledge with read data captured at the accept edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r <= 1'b0;
            dat_r <= 32'h0000_0000;
        end else begin
            ack_r <= acc_s;
            dat_r <= acc_s ? rd_word_s : 32'h0000_0000;
        end
    end

    // Combined interrupt, sampled from the state before each edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |irq_cond_s;
        end
    end

    assign ack_o = ack_r;
    assign dat_o = dat_r;
    assign irq   = irq_r;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [7:0]       tx_mem_r [DEPTH];
        logic [7:0]       rx_mem_r [DEPTH];
        logic [PTR_W-1:0] tx_wr_r;
        logic [PTR_W-1:0] tx_rd_r;
        logic [PTR_W-1:0] rx_wr_r;
        logic [PTR_W-1:0] rx_rd_r;
        logic [CNT_W-1:0] tx_cnt_r;
        logic [CNT_W-1:0] rx_cnt_r;
        logic             txdrop_r;
        logic [1:0]       ie_r;

        logic hit_s;
        logic tx_full_s;
        logic tx_empty_s;
        logic rx_full_s;
        logic rx_empty_s;
        logic tx_wr_req_s;
        logic tx_push_s;
        logic tx_drop_s;
        logic tx_pop_s;
        logic tx_flush_s;
        logic rx_push_s;
        logic rx_pop_s;
        logic rx_flush_s;
        logic drop_clr_s;
        logic ie_wr_s;

        // Channel-local decode; full/empty come from pre-edge counts
        always_comb begin
            hit_s       = acc_s & ch_valid_s & (ch_idx_s == CH_W'(c));
            tx_full_s   = (tx_cnt_r == CNT_W'(DEPTH));
            tx_empty_s  = (tx_cnt_r == {CNT_W{1'b0}});
            rx_full_s   = (rx_cnt_r == CNT_W'(DEPTH));
            rx_empty_s  = (rx_cnt_r == {CNT_W{1'b0}});
            tx_wr_req_s = hit_s & we_i & (reg_sel_s == REG_DATA) & sel_i[0];
            tx_push_s   = tx_wr_req_s & ~tx_full_s;
            tx_drop_s   = tx_wr_req_s & tx_full_s;
            tx_pop_s    = ~tx_empty_s & tx_ready[c];
            tx_flush_s  = hit_s & we_i & (reg_sel_s == REG_STATUS) & sel_i[1] & dat_i[9];
            rx_flush_s  = hit_s & we_i & (reg_sel_s == REG_STATUS) & sel_i[1] & dat_i[8];
            drop_clr_s  = hit_s & we_i & (reg_sel_s == REG_STATUS) & sel_i[0] & dat_i[4];
            rx_push_s   = rx_valid[c] & ~rx_full_s;
            rx_pop_s    = hit_s & ~we_i & (reg_sel_s == REG_DATA) & ~rx_empty_s;
            ie_wr_s     = hit_s & we_i & (reg_sel_s == REG_IE) & sel_i[0];
        end

        // TX FIFO storage; no reset needed since pointers gate visibility
        always_ff @(posedge clk) begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_r] <= dat_i[7:0];
            end
        end

        // RX FIFO storage
        always_ff @(posedge clk) begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_r] <= rx_data[8*c +: 8];
            end
        end

        // TX pointers and count; a flush overrides any concurrent pop
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                tx_wr_r  <= {PTR_W{1'b0}};
                tx_rd_r  <= {PTR_W{1'b0}};
                tx_cnt_r <= {CNT_W{1'b0}};
            end else if (tx_flush_s) begin
                tx_wr_r  <= {PTR_W{1'b0}};
                tx_rd_r  <= {PTR_W{1'b0}};
                tx_cnt_r <= {CNT_W{1'b0}};
            end else begin
                if (tx_push_s) begin
                    tx_wr_r <= tx_wr_r + PTR_W'(1'b1);
                end
                if (tx_pop_s) begin
                    tx_rd_r <= tx_rd_r + PTR_W'(1'b1);
                end
                case ({tx_push_s, tx_pop_s})
                    2'b10:   tx_cnt_r <= tx_cnt_r + CNT_W'(1'b1);
                    2'b01:   tx_cnt_r <= tx_cnt_r - CNT_W'(1'b1);
                    default: tx_cnt_r <= tx_cnt_r;
                endcase
            end
        end

        // RX pointers and count; a flush discards a byte handshaked on the same edge
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rx_wr_r  <= {PTR_W{1'b0}};
                rx_rd_r  <= {PTR_W{1'b0}};
                rx_cnt_r <= {CNT_W{1'b0}};
            end else if (rx_flush_s) begin
                rx_wr_r  <= {PTR_W{1'b0}};
                rx_rd_r  <= {PTR_W{1'b0}};
                rx_cnt_r <= {CNT_W{1'b0}};
            end else begin
                if (rx_push_s) begin
                    rx_wr_r <= rx_wr_r + PTR_W'(1'b1);
                end
                if (rx_pop_s) begin
                    rx_rd_r <= rx_rd_r + PTR_W'(1'b1);
                end
                case ({rx_push_s, rx_pop_s})
                    2'b10:   rx_cnt_r <= rx_cnt_r + CNT_W'(1'b1);
                    2'b01:   rx_cnt_r <= rx_cnt_r - CNT_W'(1'b1);
                    default: rx_cnt_r <= rx_cnt_r;
                endcase
            end
        end

        // Sticky TX drop flag and interrupt enables
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                txdrop_r <= 1'b0;
                ie_r     <= 2'b00;
            end else begin
                if (tx_drop_s) begin
                    txdrop_r <= 1'b1;
                end else if (drop_clr_s) begin
                    txdrop_r <= 1'b0;
                end
                if (ie_wr_s) begin
                    ie_r <= dat_i[1:0];
                end
            end
        end

        assign tx_data[8*c +: 8] = tx_mem_r[tx_rd_r];
        assign tx_valid[c]       = ~tx_empty_s;
        assign rx_ready[c]       = ~rx_full_s;

        assign data_word_s[c]   = rx_empty_s ? 32'h0000_0000
                                             : {1'b1, 23'h00_0000, rx_mem_r[rx_rd_r]};
        assign status_word_s[c] = {27'h000_0000, txdrop_r, tx_full_s, tx_empty_s,
                                   rx_full_s, ~rx_empty_s};
        assign level_word_s[c]  = {16'(tx_cnt_r), 16'(rx_cnt_r)};
        assign ie_word_s[c]     = {30'h0000_0000, ie_r};
        assign irq_cond_s[c]    = (ie_r[0] & ~rx_empty_s) | (ie_r[1] & tx_empty_s);
    end

endmodule
